// File: rtl/minterm_sweeper_if.sv
// Row stream between the minterm sweeper and its consumer.
// The sweeper drives the row; the consumer drives out_ready.
interface minterm_sweeper_if #(
    parameter int N = 4,
    parameter int C = 5
);
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_idx;
    logic [C-1:0] out_bits;

    modport master (
        output out_valid,
        output out_idx,
        output out_bits,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_bits,
        output out_ready
    );
endinterface

// File: rtl/minterm_sweeper.sv
// Bank of C programmable N-input sum-of-minterms functions.
// A sweep streams the full truth table and counts the 1 rows per channel.
module minterm_sweeper #(
    parameter int N  = 4,
    parameter int C  = 5,
    parameter int CW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [2**N-1:0]   cfg_mask,
    input  logic              start,
    minterm_sweeper_if.master out,
    output logic              busy,
    output logic              done,
    input  logic [CW-1:0]     count_sel,
    output logic [N:0]        count
);
    localparam int DEPTH = 2**N;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state;
    logic [DEPTH-1:0] mask     [C];
    logic [DEPTH-1:0] eff_mask [C];
    logic [N:0]       cnt      [C];
    logic [N-1:0]     idx_next;
    logic             xfer;

    assign xfer     = (state == SWEEP) && out.out_valid && out.out_ready;
    assign idx_next = out.out_idx + N'(1);

    // A write in the start cycle must be visible to row 0, so row 0 reads the
    // mask as it will be after this edge rather than the stored copy.
    always_comb begin
        for (int unsigned c = 0; c < C; c++) begin
            eff_mask[c] = mask[c];
            if (state == IDLE && cfg_we && cfg_ch == CW'(c))
                eff_mask[c] = cfg_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            out.out_valid <= 1'b0;
            out.out_idx   <= '0;
            out.out_bits  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int unsigned c = 0; c < C; c++) begin
                mask[c] <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    for (int unsigned c = 0; c < C; c++)
                        mask[c] <= eff_mask[c];
                    if (start) begin
                        state         <= SWEEP;
                        out.out_valid <= 1'b1;
                        busy          <= 1'b1;
                        out.out_idx   <= '0;
                        for (int unsigned c = 0; c < C; c++) begin
                            cnt[c]          <= '0;
                            out.out_bits[c] <= eff_mask[c][0];
                        end
                    end
                end
                SWEEP: begin
                    if (xfer) begin
                        for (int unsigned c = 0; c < C; c++)
                            cnt[c] <= cnt[c] + {{N{1'b0}}, out.out_bits[c]};
                        if (&out.out_idx) begin
                            state         <= DONE;
                            out.out_valid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            out.out_idx <= idx_next;
                            for (int unsigned c = 0; c < C; c++)
                                out.out_bits[c] <= mask[c][idx_next];
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned c = 0; c < C; c++)
            if (count_sel == CW'(c))
                count = cnt[c];
    end
endmodule

// File: doc/minterm_sweeper.md
Name: minterm_sweeper

Overview:
- Parametrised successor of the team's fixed 4-input sum-of-minterms function blocks.
- Holds C independently programmable minterm masks, one per output channel. Each mask defines an N-variable function as Σm.
- On start, sweeps every input combination 0..2^N-1 and streams each row out with a ready/valid handshake. Per-channel 1-counts accumulate during the sweep.
- Used as the self-checking truth-table source for the Guia function exercises, and as a generic programmable LUT bank.

Parameters:
- N, default 4, number of input variables; table depth is 2^N.
- C, default 5, number of function channels.
- CW, default 3, channel-select width; must satisfy 2^CW >= C.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  mask write strobe.
- cfg_ch  input  CW  channel written by cfg_we.
- cfg_mask  input  2^N  minterm mask; bit k=1 means minterm k is in the function.
- start  input  1  begin a sweep (level-sampled).
- out_ready  input  1  consumer accepts the current row.
- out_valid  output  1  a row is presented.
- out_idx  output  N  minterm index of the presented row (bit N-1 = x, MSB).
- out_bits  output  C  function values; bit c = mask[c][out_idx].
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse after the last row transfers.
- count_sel  input  CW  channel whose 1-count is shown.
- count  output  N+1  number of 1 rows transferred for channel count_sel.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all masks=0; all counters=0; idx=0.
  - out_valid=0, busy=0, done=0, out_bits=0, out_idx=0.
  - Reset asserted mid-sweep aborts the sweep on that edge. No done pulse is produced.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - cfg_we=1 with cfg_ch<C writes cfg_mask into mask[cfg_ch] at the clock edge.
  - cfg_ch>=C is ignored.
  - start=1 moves to SWEEP next cycle, clears idx and all counts, and raises busy.
  - If start and cfg_we occur in the same cycle, the write lands first; the sweep uses the new mask.
- SWEEP:
  - out_valid=1, busy=1, out_idx=idx.
  - out_bits is registered but reflects mask[c][idx] for the current idx. There is no bubble between rows.
  - A transfer occurs on any cycle with out_valid & out_ready. On transfer, count[c] += out_bits[c] for every c, and idx += 1.
  - With out_ready=0, idx, out_bits and the counts hold, and out_valid stays 1.
  - A transfer at idx=2^N-1 moves to DONE. idx does not wrap into a second pass.
  - cfg_we and start are ignored; masks are frozen during a sweep.
- DONE:
  - Lasts exactly one cycle: done=1, out_valid=0, busy=0. Then returns to IDLE.
  - A start sampled in DONE is ignored.
- Latency with out_ready held high:
  - start sampled at edge t gives the first row (idx 0) visible after edge t.
  - Last row at t+2^N-1; done visible after edge t+2^N.
  - Back-to-back start is accepted at the earliest in the first IDLE cycle after DONE.
- count:
  - Combinational mux of the internal counters by count_sel; count_sel>=C gives 0.
  - Counters saturate cannot occur: max value is 2^N, which fits in N+1 bits.
  - Counts hold after DONE until the next start.

Test Plan:
- Reset, then write ch0=0x88CA (Σm 1,3,6,7,11,15), ch1=0x222D, ch2=0x152F, and start with out_ready=1.
  - Rows idx 0..15 stream on consecutive cycles; out_bits[0] is 1 exactly at 1,3,6,7,11,15.
  - done pulses 16 cycles after the first row; count(ch0)=6, count(ch1)=6, count(ch2)=8.
- Same setup, with out_ready toggled 1,0,0,1,... during the sweep.
  - On stall cycles idx and out_bits hold.
  - Each idx 0..15 transfers exactly once; final counts are identical to the first scenario.
- Write ch3=0xFFFF and ch4=0x0000, then sweep.
  - count(ch3)=16 (=5'b10000); count(ch4)=0; count_sel=7 reads 0.
- During SWEEP at idx=5, pulse cfg_we ch0=0x0001 and pulse start.
  - Both are ignored: the sweep continues to idx 6 and the ch0 mask is still 0x88CA on the next sweep.
- Assert reset at idx=9.
  - Next cycle: out_valid=0, busy=0, no done pulse, all masks=0.
  - A following sweep yields out_bits=0 for all 16 rows.
- Drive cfg_we ch1=0x0003 and start in the same cycle.
  - Rows 0 and 1 show out_bits[1]=1, all other rows 0; count(ch1)=2.
